// File: rtl/mole_key_encoder.sv
// mole_key_encoder: debounces nine active-high mole buttons and reports each
// accepted press as a one-cycle hole index on one_pulse_pos (15 when idle).
// Each button goes through a 2-flop synchronizer and then its own debounce
// counter. A debounced level change is accepted after DEBOUNCE_CYCLES
// consecutive stable cycles.
// Optional feature: define MOLE_KEY_LOCKOUT_EN to ignore further presses after
// an accepted one, until every button has been seen released for a cycle.
module mole_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] btn,
  input  logic       en,
  output logic [3:0] one_pulse_pos,
  output logic [8:0] key_state
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]        POS_IDLE = 4'hF;

  logic [8:0]       sync1_q, sync1_d;
  logic [8:0]       sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q [9];
  logic [CNT_W-1:0] cnt_d [9];
  logic [8:0]       key_state_q, key_state_d;
  logic [8:0]       key_prev_q, key_prev_d;
  logic [3:0]       pos_q, pos_d;
  logic [8:0]       press;
  logic             accept_ok;
  logic             found;

`ifdef MOLE_KEY_LOCKOUT_EN
  logic             lock_q, lock_d;
`endif

  // Synchronizer next state: raw buttons are asynchronous to clk
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
  end

  // Debounce: count while the synchronized level differs from the accepted
  // level. Accept the new level on the edge where the count would reach
  // DEBOUNCE_CYCLES. Any agreement clears the count, so glitches are lost.
  always_comb begin
    key_state_d = key_state_q;
    for (int i = 0; i < 9; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == key_state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        key_state_d[i] = sync2_q[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Press detection: rising edges of the debounced level. Report the lowest
  // index only. Drop the rest, and drop everything when presses are gated off.
  always_comb begin
    key_prev_d = key_state_q;
    press      = key_state_q & ~key_prev_q;
`ifdef MOLE_KEY_LOCKOUT_EN
    accept_ok  = en & ~lock_q;
`else
    accept_ok  = en;
`endif
    pos_d = POS_IDLE;
    found = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (press[i] && !found) begin
        pos_d = 4'(i);
        found = 1'b1;
      end
    end
    if (!accept_ok) begin
      pos_d = POS_IDLE;
    end
  end

`ifdef MOLE_KEY_LOCKOUT_EN
  // Lockout: set on an accepted press, cleared once all keys read released
  always_comb begin
    lock_d = lock_q;
    if (lock_q && (key_state_q == 9'd0)) begin
      lock_d = 1'b0;
    end else if (found && accept_ok) begin
      lock_d = 1'b1;
    end
  end

  // Lockout flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

  // State registers: synchronizers, debounce counters, levels and the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      key_state_q <= '0;
      key_prev_q  <= '0;
      pos_q       <= POS_IDLE;
      for (int i = 0; i < 9; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      key_state_q <= key_state_d;
      key_prev_q  <= key_prev_d;
      pos_q       <= pos_d;
      for (int i = 0; i < 9; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign one_pulse_pos = pos_q;
  assign key_state     = key_state_q;

endmodule

// File: tb/tb_mole_key_encoder.sv
// Testbench for mole_key_encoder with DEBOUNCE_CYCLES=4. The stimulus pushes
// the expected pulses (hole index and the cycle they must appear on) into a
// scoreboard queue. A monitor pops and compares every pulse the DUT emits.
module tb_mole_key_encoder;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  typedef struct {
    int pos;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] btn;
  logic       en;
  logic [3:0] one_pulse_pos;
  logic [8:0] key_state;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  mole_key_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn),
    .en            (en),
    .one_pulse_pos (one_pulse_pos),
    .key_state     (key_state)
  );

  always #5 clk = ~clk;

  // Count rising edges so expected pulse times can be stated in cycles
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect a pulse for hole p, LAT edges after the next rising edge samples
  task automatic expect_pulse(input int p);
    exp_t e;
    e.pos = p;
    e.cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  // Monitor: compare every emitted pulse against the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      check("missing_pulse", 15, e.pos);
    end
    if (one_pulse_pos != 4'hF) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", int'(one_pulse_pos), 15);
      end else begin
        e = sb.pop_front();
        check("pulse_pos", int'(one_pulse_pos), e.pos);
        check("pulse_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    btn   = '0;
    en    = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check("rst_pos", int'(one_pulse_pos), 15);
    check("rst_key", int'(key_state), 0);
    rst_n = 1'b1;
    tick(3);

    // Clean press of hole 3, with exact debounce timing on key_state
    btn[3] = 1'b1;
    expect_pulse(3);
    tick(DEB + 1);
    check("clean_key_early", int'(key_state), 0);
    tick(1);
    check("clean_key", int'(key_state), 9'h008);
    tick(8);
    btn[3] = 1'b0;
    tick(10);
    check("clean_release", int'(key_state), 0);

    // Glitch on hole 5, shorter than the debounce window
    btn[5] = 1'b1;
    tick(3);
    btn[5] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("glitch_key", int'(key_state), 0);
    end
    tick(4);

    // Simultaneous press of holes 7 and 2: only 2 is reported
    btn[7] = 1'b1;
    btn[2] = 1'b1;
    expect_pulse(2);
    tick(12);
    check("simul_key", int'(key_state), 9'h084);
    btn = '0;
    tick(10);

    // Enable gate: press while disabled, enable while held, release, re-press
    en     = 1'b0;
    btn[0] = 1'b1;
    tick(10);
    en = 1'b1;
    tick(6);
    btn[0] = 1'b0;
    tick(10);
    btn[0] = 1'b1;
    expect_pulse(0);
    tick(10);
    btn[0] = 1'b0;
    tick(10);

    // Lockout: hold 1, press 4, release all, press 4 again
    btn[1] = 1'b1;
    expect_pulse(1);
    tick(10);
    btn[4] = 1'b1;
`ifndef MOLE_KEY_LOCKOUT_EN
    expect_pulse(4);
`endif
    tick(10);
    check("lock_key", int'(key_state), 9'h012);
    btn = '0;
    tick(10);
    btn[4] = 1'b1;
    expect_pulse(4);
    tick(10);
    btn = '0;
    tick(10);

    // Reset while hole 6 is still being debounced, then release with it held
    btn[6] = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("midrst_pos", int'(one_pulse_pos), 15);
    check("midrst_key", int'(key_state), 0);
    tick(2);
    rst_n = 1'b1;
    expect_pulse(6);
    tick(12);
    check("midrst_held_key", int'(key_state), 9'h040);
    btn = '0;
    tick(10);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mole_key_encoder.md
MOLE_KEY_ENCODER -- requirements
Module: mole_key_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port btn  input  9  raw active-high mole buttons, bit i = hole i; asynchronous to clk and bouncy.
REQ-005 SHALL have port en  input  1  accept presses; driven high by game control while a round is running.
REQ-006 SHALL have port one_pulse_pos  output  4  registered hole index 0..8 for one cycle per accepted press, else 15.
REQ-007 SHALL have port key_state  output  9  registered debounced level of each button.

Function
REQ-008 SHALL pass each btn bit through a 2-flop synchronizer before any other logic.
REQ-009 SHALL keep one debounce counter per button, width ceil(log2(DEBOUNCE_CYCLES+1)), with no wrap.
REQ-010 Counter i SHALL clear whenever the synchronized bit equals key_state[i], and SHALL increment otherwise.
REQ-011 When counter i would reach DEBOUNCE_CYCLES, key_state[i] SHALL take the synchronized value on that edge, and the counter SHALL clear.
REQ-012 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave key_state unchanged and SHALL produce no pulse.
REQ-013 A press edge SHALL be a 0->1 transition of key_state[i]; release edges SHALL never produce a pulse.
REQ-014 On the edge after a press edge, if accepted, one_pulse_pos SHALL equal i for exactly one cycle, then return to 15.
REQ-015 End-to-end latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges, counted from the first edge that samples btn[i] high, for a bounce-free press.
REQ-016 If several press edges occur in the same cycle, the lowest index SHALL be reported; the others SHALL be dropped, not queued.
REQ-017 Press edges occurring while en=0 SHALL be dropped; debouncing and key_state SHALL keep running regardless of en.
REQ-018 A button held across an en 0->1 transition SHALL NOT produce a pulse; only a new press edge counts.
REQ-019 one_pulse_pos SHALL never take values 9..14.

Reset
REQ-020 While rst_n=0, synchronizers, counters and key_state SHALL be 0, one_pulse_pos SHALL be 15, and the lockout flag SHALL be 0, asynchronously.
REQ-021 After rst_n deassertion mid-press, a still-held button SHALL be debounced from zero and SHALL produce one pulse after the full REQ-015 latency.

Configuration
REQ-022 SHALL support the macro MOLE_KEY_LOCKOUT_EN.
REQ-023 With MOLE_KEY_LOCKOUT_EN defined, after an accepted press a lockout flag SHALL set, and all press edges SHALL be dropped until key_state==0 has been seen for one cycle.
REQ-024 Without MOLE_KEY_LOCKOUT_EN, every press edge SHALL be accepted independently per REQ-016/017, and no lockout logic SHALL exist.

Verification (DEBOUNCE_CYCLES=4 for all scenarios)
REQ-025 Bench SHALL cover a clean press: en=1, btn[3] 0->1 and held -> one_pulse_pos=3 for exactly one cycle, 7 edges after the first sampling edge; key_state=9'h008.
REQ-026 Bench SHALL cover a glitch: btn[5] high for 3 cycles, then low -> one_pulse_pos stays 15 and key_state stays 0.
REQ-027 Bench SHALL cover a simultaneous press: btn[7] and btn[2] rise on the same edge -> a single pulse with value 2, and no later pulse with value 7.
REQ-028 Bench SHALL cover the enable gate: en=0, press btn[0]; raise en while held; release; then press again -> no pulse until the second press, which reports 0.
REQ-029 Bench SHALL cover lockout: with MOLE_KEY_LOCKOUT_EN, hold btn[1], then press btn[4] -> only 1 is reported; release all, press btn[4] -> 4. Without the macro the same stimulus -> pulses 1, 4, then 4.
REQ-030 Bench SHALL cover reset mid-operation: assert rst_n=0 during the counting of btn[6] -> outputs go to 15 and 0 immediately; deassert with btn[6] held -> a single pulse with value 6, 7 edges later.
